// File: rtl/exec_core_pkg.sv
// Shared types and constants for the RV32I execution core: ALU modes,
// operand/destination selector encodings, opcode values and the 32-bit
// integer typedefs used by exec_core and exec_alu.
package exec_core_pkg;

    typedef logic signed [31:0] int32_t;
    typedef logic [31:0]        uint32_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_COPY_B
    } alu_mode_t;

    typedef enum logic {
        ALU_A_REG = 1'b0,
        ALU_A_PC  = 1'b1
    } alu_in_a_t;

    typedef enum logic {
        ALU_B_REG = 1'b0,
        ALU_B_IMM = 1'b1
    } alu_in_b_t;

    typedef enum logic [1:0] {
        DEST_NONE   = 2'd0,
        DEST_ALU    = 2'd1,
        DEST_MEM    = 2'd2,
        DEST_PC_LEN = 2'd3
    } dest_reg_from_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Map funct3 to an ALU mode for OP / OP-IMM. 'alt' picks SUB over ADD
    // and SRA over SRL; the caller decides when alt is allowed.
    function automatic alu_mode_t arith_mode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/exec_core_alu.sv
// exec_alu: purely combinational 32-bit ALU (A, B, mode -> result).
// Shift amounts come from B[4:0]; compares return 1 or 0.
module exec_alu
    import exec_core_pkg::*;
(
    input  uint32_t   a_i,
    input  uint32_t   b_i,
    input  alu_mode_t mode_i,
    output uint32_t   result_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    // Select the result for the requested operation
    always_comb begin
        result_o = '0;
        case (mode_i)
            ALU_ADD:    result_o = a_i + b_i;
            ALU_SUB:    result_o = a_i - b_i;
            ALU_SLL:    result_o = a_i << shamt;
            ALU_SLT:    result_o = {31'b0, int32_t'(a_i) < int32_t'(b_i)};
            ALU_SLTU:   result_o = {31'b0, a_i < b_i};
            ALU_XOR:    result_o = a_i ^ b_i;
            ALU_SRL:    result_o = a_i >> shamt;
            ALU_SRA:    result_o = uint32_t'(int32_t'(a_i) >>> shamt);
            ALU_OR:     result_o = a_i | b_i;
            ALU_AND:    result_o = a_i & b_i;
            ALU_COPY_B: result_o = b_i;
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/exec_core.sv
// exec_core: RV32I execution core. Two-state control (FETCH / EXECUTE),
// instruction decode into ALU mode and mux selects, branch resolution and
// the PC register. Optional retirement trace under EXEC_CORE_TRACE_EN.
module exec_core
    import exec_core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  f3,
    input  logic [6:0]  f7,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] imm,
    input  logic [31:0] cur_pc,
    input  logic [31:0] instr_len,
    input  logic        stall,
    input  logic        debug_wait,
    output logic        fetch_next_instruction,
    output logic        load_ir,
    output logic        dbus_re,
    output logic        dbus_we,
    output logic        load_rd,
    output logic        alu_in_a_sel,
    output logic        alu_in_b_sel,
    output logic [1:0]  dest_reg_from,
    output logic [31:0] alu_out,
    output logic [31:0] next_pc
);

    localparam logic [0:0] ST_FETCH   = 1'b0;
    localparam logic [0:0] ST_EXECUTE = 1'b1;

    logic [0:0]     state_q, state_d;
    uint32_t        pc_q, pc_d;

    alu_mode_t      alu_mode;
    alu_in_a_t      a_sel;
    alu_in_b_t      b_sel;
    dest_reg_from_t dest;
    logic           pc_load;
    logic           clear_lsb;
    logic           branch_op;
    logic           branch_inv;
    logic           mem_rd;
    logic           mem_wr;

    uint32_t        op_a, op_b, alu_res;
    uint32_t        pc_step, jump_target;
    logic           in_exec, retire, taken;
    logic           unused_f7;

    // Only f7[5] carries meaning for the supported instructions
    assign unused_f7 = ^{f7[6], f7[4:0]};

    assign in_exec = (state_q == ST_EXECUTE);
    assign retire  = in_exec && !stall;

    // Decode the instruction in IR; everything stays idle outside EXECUTE
    always_comb begin
        alu_mode   = ALU_ADD;
        a_sel      = ALU_A_REG;
        b_sel      = ALU_B_REG;
        dest       = DEST_NONE;
        pc_load    = 1'b0;
        clear_lsb  = 1'b0;
        branch_op  = 1'b0;
        branch_inv = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        if (in_exec) begin
            case (opcode)
                OPC_OP: begin
                    alu_mode = arith_mode(f3, f7[5]);
                    dest     = DEST_ALU;
                end
                OPC_OP_IMM: begin
                    // ADDI has no subtract form; f7[5] only matters for SRAI
                    b_sel    = ALU_B_IMM;
                    alu_mode = arith_mode(f3, f7[5] && (f3 == 3'b101));
                    dest     = DEST_ALU;
                end
                OPC_LUI: begin
                    b_sel    = ALU_B_IMM;
                    alu_mode = ALU_COPY_B;
                    dest     = DEST_ALU;
                end
                OPC_AUIPC: begin
                    a_sel = ALU_A_PC;
                    b_sel = ALU_B_IMM;
                    dest  = DEST_ALU;
                end
                OPC_JAL: begin
                    a_sel   = ALU_A_PC;
                    b_sel   = ALU_B_IMM;
                    dest    = DEST_PC_LEN;
                    pc_load = 1'b1;
                end
                OPC_JALR: begin
                    b_sel     = ALU_B_IMM;
                    dest      = DEST_PC_LEN;
                    pc_load   = 1'b1;
                    clear_lsb = 1'b1;
                end
                OPC_BRANCH: begin
                    // XOR is nonzero when operands differ, so BEQ inverts;
                    // compares are 1 when less-than, so BGE/BGEU invert.
                    branch_op = 1'b1;
                    case (f3)
                        3'b000: begin alu_mode = ALU_XOR;  branch_inv = 1'b1; end
                        3'b001: begin alu_mode = ALU_XOR;  branch_inv = 1'b0; end
                        3'b100: begin alu_mode = ALU_SLT;  branch_inv = 1'b0; end
                        3'b101: begin alu_mode = ALU_SLT;  branch_inv = 1'b1; end
                        3'b110: begin alu_mode = ALU_SLTU; branch_inv = 1'b0; end
                        3'b111: begin alu_mode = ALU_SLTU; branch_inv = 1'b1; end
                        default: branch_op = 1'b0; // reserved encodings never branch
                    endcase
                end
                OPC_LOAD: begin
                    b_sel  = ALU_B_IMM;
                    dest   = DEST_MEM;
                    mem_rd = 1'b1;
                end
                OPC_STORE: begin
                    b_sel  = ALU_B_IMM;
                    mem_wr = 1'b1;
                end
                default: begin
                    dest = DEST_NONE;
                end
            endcase
        end
    end

    assign op_a = (a_sel == ALU_A_PC)  ? cur_pc : rs1_val;
    assign op_b = (b_sel == ALU_B_IMM) ? imm    : rs2_val;

    exec_alu u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .mode_i   (alu_mode),
        .result_o (alu_res)
    );

    assign taken       = branch_op && ((alu_res != 32'd0) ^ branch_inv);
    assign pc_step     = taken ? imm : instr_len;
    assign jump_target = clear_lsb ? {alu_res[31:1], 1'b0} : alu_res;

    // Next PC: jumps load the target, otherwise step; hold unless retiring
    always_comb begin
        pc_d = pc_q;
        if (retire) begin
            if (pc_load) begin
                pc_d = jump_target;
            end else begin
                pc_d = pc_q + pc_step;
            end
        end
    end

    // Control sequencing between fetch and execute
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:   if (!debug_wait && !stall) state_d = ST_EXECUTE;
            ST_EXECUTE: if (!stall)                state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    // State and PC registers; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef EXEC_CORE_TRACE_EN
    // Report every retiring instruction and the PC it leaves behind
    always_ff @(posedge clk) begin
        if (rst && retire) begin
            $display("%0t exec_core: pc=%08h op=%07b alu=%08h next_pc=%08h",
                     $time, cur_pc, opcode, alu_res, pc_d);
        end
    end
`endif

    assign fetch_next_instruction = !in_exec;
    assign load_ir                = !in_exec;
    assign dbus_re                = mem_rd;
    assign dbus_we                = mem_wr;
    assign load_rd                = retire && (dest != DEST_NONE);
    assign alu_in_a_sel           = a_sel;
    assign alu_in_b_sel           = b_sel;
    assign dest_reg_from          = dest;
    assign alu_out                = alu_res;
    assign next_pc                = pc_q;

endmodule

// File: tb/tb_exec_core.sv
// Self-checking bench for exec_core: directed cases with literal results,
// then randomized instructions compared every cycle against a model.
module tb_exec_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1_val, rs2_val, imm, cur_pc, instr_len;
    logic        stall, debug_wait;
    logic        fetch_next_instruction, load_ir, dbus_re, dbus_we, load_rd;
    logic        alu_in_a_sel, alu_in_b_sel;
    logic [1:0]  dest_reg_from;
    logic [31:0] alu_out, next_pc;

    int total = 0;
    int bad   = 0;

    logic        m_exec;
    logic [31:0] m_pc;

    exec_core dut (
        .clk                    (clk),
        .rst                    (rst),
        .opcode                 (opcode),
        .f3                     (f3),
        .f7                     (f7),
        .rs1_val                (rs1_val),
        .rs2_val                (rs2_val),
        .imm                    (imm),
        .cur_pc                 (cur_pc),
        .instr_len              (instr_len),
        .stall                  (stall),
        .debug_wait             (debug_wait),
        .fetch_next_instruction (fetch_next_instruction),
        .load_ir                (load_ir),
        .dbus_re                (dbus_re),
        .dbus_we                (dbus_we),
        .load_rd                (load_rd),
        .alu_in_a_sel           (alu_in_a_sel),
        .alu_in_b_sel           (alu_in_b_sel),
        .dest_reg_from          (dest_reg_from),
        .alu_out                (alu_out),
        .next_pc                (next_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_arith(input logic [2:0] fn, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (fn)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << s;
            3'd2: return ((a[31] != b[31]) ? a[31] : (a < b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? ((a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0)) : (a >> s);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic m_known(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                          7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
    endfunction

    function automatic logic [31:0] m_alu(input logic [6:0] op, input logic [2:0] fn3,
                                          input logic [6:0] fn7, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] im,
                                          input logic [31:0] pc);
        case (op)
            7'b0110011: return m_arith(fn3, fn7[5], a, b);
            7'b0010011: return m_arith(fn3, fn7[5] && fn3 == 3'd5, a, im);
            7'b0110111: return im;
            7'b0010111, 7'b1101111: return pc + im;
            7'b1100111, 7'b0000011, 7'b0100011: return a + im;
            7'b1100011: begin
                if (fn3[2:1] == 2'b00) return a ^ b;
                if (fn3[2:1] == 2'b10) return m_arith(3'd2, 1'b0, a, b);
                return (a < b) ? 32'd1 : 32'd0;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_dest(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 2'd1;
            7'b0000011: return 2'd2;
            7'b1101111, 7'b1100111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic m_taken(input logic [2:0] fn3, input logic [31:0] a, input logic [31:0] b);
        case (fn3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_npc(input logic [31:0] pc_reg);
        if (opcode == 7'b1101111) return cur_pc + imm;
        if (opcode == 7'b1100111) return (rs1_val + imm) & 32'hFFFF_FFFE;
        if (opcode == 7'b1100011 && m_taken(f3, rs1_val, rs2_val)) return pc_reg + imm;
        return pc_reg + instr_len;
    endfunction

    // Model state: which phase the core is in and the expected PC
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_exec <= 1'b0;
            m_pc   <= 32'd0;
        end else if (!m_exec) begin
            if (!debug_wait && !stall) m_exec <= 1'b1;
        end else if (!stall) begin
            m_exec <= 1'b0;
            m_pc   <= m_npc(m_pc);
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        if (rst) begin
            chk("next_pc", next_pc, m_pc);
            if (m_exec) begin
                chk("x_fetch", {31'd0, fetch_next_instruction}, 32'd0);
                chk("x_load_ir", {31'd0, load_ir}, 32'd0);
                chk("x_dest", {30'd0, dest_reg_from}, {30'd0, m_dest(opcode)});
                chk("x_asel", {31'd0, alu_in_a_sel},
                    {31'd0, opcode == 7'b0010111 || opcode == 7'b1101111});
                chk("x_bsel", {31'd0, alu_in_b_sel},
                    {31'd0, m_known(opcode) && opcode != 7'b0110011 && opcode != 7'b1100011});
                chk("x_re", {31'd0, dbus_re}, {31'd0, opcode == 7'b0000011});
                chk("x_we", {31'd0, dbus_we}, {31'd0, opcode == 7'b0100011});
                chk("x_load_rd", {31'd0, load_rd}, {31'd0, !stall && m_dest(opcode) != 2'd0});
                if (m_known(opcode))
                    chk("x_alu", alu_out, m_alu(opcode, f3, f7, rs1_val, rs2_val, imm, cur_pc));
            end else begin
                chk("f_fetch", {31'd0, fetch_next_instruction}, 32'd1);
                chk("f_load_ir", {31'd0, load_ir}, 32'd1);
                chk("f_strobes", {28'd0, dbus_re, dbus_we, load_rd, 1'b0}, 32'd0);
                chk("f_sels", {28'd0, alu_in_a_sel, alu_in_b_sel, dest_reg_from}, 32'd0);
            end
        end
    end

    // Run one instruction from FETCH: nstall stalled EXECUTE cycles, then retire
    task automatic run_instr(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                             input logic [31:0] pc, input int nstall,
                             output logic [31:0] alu_s, output logic [1:0] dest_s,
                             output int re_n, output int rd_n);
        opcode = op; f3 = fn3; f7 = fn7; rs1_val = a; rs2_val = b; imm = im; cur_pc = pc;
        stall = 1'b0; debug_wait = 1'b0;
        re_n = 0; rd_n = 0; alu_s = '0; dest_s = '0;
        @(posedge clk); #1;
        for (int i = 0; i <= nstall; i++) begin
            stall = (i < nstall);
            @(negedge clk);
            if (dbus_re) re_n++;
            if (load_rd) rd_n++;
            alu_s  = alu_out;
            dest_s = dest_reg_from;
            @(posedge clk); #1;
        end
        stall = 1'b0;
    endtask

    logic [31:0] a_s;
    logic [1:0]  d_s;
    int          re_c, rd_c;
    logic [6:0]  op_tab [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b1111111};

    initial begin
        rst = 1'b0; opcode = '0; f3 = '0; f7 = '0; rs1_val = '0; rs2_val = '0;
        imm = '0; cur_pc = '0; instr_len = 32'd4; stall = 1'b0; debug_wait = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_fetch", {31'd0, fetch_next_instruction}, 32'd1);
        chk("rst_strobes", {27'd0, dbus_re, dbus_we, load_rd, alu_in_a_sel, alu_in_b_sel}, 32'd0);
        chk("rst_dest", {30'd0, dest_reg_from}, 32'd0);
        rst = 1'b1;

        run_instr(7'b0010011, 3'd0, 7'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'd0, 0, a_s, d_s, re_c, rd_c);
        chk("addi_alu", a_s, 32'd2);
        chk("addi_dest", {30'd0, d_s}, 32'd1);
        chk("addi_rd_pulses", rd_c, 32'd1);
        chk("addi_pc", next_pc, 32'd4);

        run_instr(7'b1101111, 3'd0, 7'd0, 32'd0, 32'd0, 32'h100, 32'd0, 0, a_s, d_s, re_c, rd_c);
        chk("jal_pc", next_pc, 32'h100);
        chk("jal_dest", {30'd0, d_s}, 32'd3);
        run_instr(7'b1100011, 3'd0, 7'd0, 32'd7, 32'd7, 32'd16, 32'h100, 0, a_s, d_s, re_c, rd_c);
        chk("beq_taken_pc", next_pc, 32'h110);
        chk("beq_rd", rd_c, 32'd0);
        run_instr(7'b1101111, 3'd0, 7'd0, 32'd0, 32'd0, 32'h100, 32'd0, 0, a_s, d_s, re_c, rd_c);
        run_instr(7'b1100011, 3'd0, 7'd0, 32'd7, 32'd8, 32'd16, 32'h100, 0, a_s, d_s, re_c, rd_c);
        chk("beq_not_taken_pc", next_pc, 32'h104);

        run_instr(7'b1100011, 3'd6, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h104, 0, a_s, d_s, re_c, rd_c);
        chk("bltu_alu", a_s, 32'd0);
        chk("bltu_pc", next_pc, 32'h108);
        run_instr(7'b1100011, 3'd4, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h108, 0, a_s, d_s, re_c, rd_c);
        chk("blt_alu", a_s, 32'd1);
        chk("blt_pc", next_pc, 32'h148);

        run_instr(7'b0000011, 3'd2, 7'd0, 32'h1000, 32'd0, 32'd8, 32'h148, 3, a_s, d_s, re_c, rd_c);
        chk("lw_re_cycles", re_c, 32'd4);
        chk("lw_rd_pulses", rd_c, 32'd1);
        chk("lw_dest", {30'd0, d_s}, 32'd2);
        chk("lw_addr", a_s, 32'h1008);
        chk("lw_pc", next_pc, 32'h14C);

        run_instr(7'b1100111, 3'd0, 7'd0, 32'h203, 32'd0, 32'd0, 32'h14C, 0, a_s, d_s, re_c, rd_c);
        chk("jalr_pc", next_pc, 32'h202);
        chk("jalr_dest", {30'd0, d_s}, 32'd3);

        run_instr(7'b0110011, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 32'd0, 32'h202, 0, a_s, d_s, re_c, rd_c);
        chk("sra_alu", a_s, 32'hF800_0000);
        chk("sra_pc", next_pc, 32'h206);

        // debug_wait holds the core in FETCH
        debug_wait = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("dbg_fetch", {31'd0, fetch_next_instruction}, 32'd1);
        chk("dbg_pc", next_pc, 32'h206);
        debug_wait = 1'b0;

        // Reset in the middle of a stalled store
        opcode = 7'b0100011; f3 = 3'd2; rs1_val = 32'h40; imm = 32'd4; cur_pc = 32'h206;
        @(posedge clk); #1;
        stall = 1'b1;
        @(negedge clk);
        chk("sw_we", {31'd0, dbus_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_pc", next_pc, 32'd0);
        chk("midrst_fetch", {31'd0, fetch_next_instruction}, 32'd1);
        chk("midrst_we", {31'd0, dbus_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; stall = 1'b0;

        // Randomized instructions, checked each cycle by the compare process
        for (int c = 0; c < 4000; c++) begin
            if (!m_exec) begin
                opcode  = op_tab[$urandom_range(0, 9)];
                f3      = 3'($urandom);
                if (opcode == 7'b1100011 && f3[2:1] == 2'b01) f3[2] = 1'b1;
                f7      = 7'($urandom);
                rs1_val = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
                rs2_val = ($urandom_range(0, 3) == 0) ? rs1_val : $urandom;
                imm     = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
                cur_pc  = ($urandom_range(0, 4) == 0) ? $urandom : m_pc;
            end
            stall      = ($urandom_range(0, 3) == 0);
            debug_wait = ($urandom_range(0, 4) == 0);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_core.md
# exec_core

Execution core of the RV32I CPU: the control state machine, the 32-bit ALU, branch resolution and the program-counter register. It sits between the instruction decoder/register file and the instruction/data memory units. It sequences each instruction through fetch and execute, steers the operand and write-back multiplexers, drives the data-bus strobes, and produces the next PC.

## Interface
No parameters.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- opcode  in  7  decoded opcode (ir[6:0])
- f3  in  3  funct3
- f7  in  7  funct7
- rs1_val, rs2_val  in  32 each  register operands
- imm  in  32  sign-extended immediate
- cur_pc  in  32  PC of the instruction in IR
- instr_len  in  32  instruction length in bytes (4)
- stall  in  1  memory unit not ready
- debug_wait  in  1  hold before the next fetch
- fetch_next_instruction, load_ir  out  1  fetch request / IR load
- dbus_re, dbus_we  out  1  data read / write strobes
- load_rd  out  1  register-file write enable
- alu_in_a_sel  out  1  0 = REG (rs1), 1 = PC
- alu_in_b_sel  out  1  0 = REG (rs2), 1 = IMM
- dest_reg_from  out  2  0 = NONE, 1 = ALU, 2 = MEM, 3 = PC+len
- alu_out  out  32  ALU result; also the data address
- next_pc  out  32  PC register

## Operation
- ALU operand A is rs1_val or cur_pc; operand B is rs2_val or imm. Operands are selected inside the block using the sel outputs.
- ALU modes:
  - ADD, SUB, XOR, OR, AND.
  - SLL, SRL, SRA: shift amount is B[4:0].
  - SLT (signed) and SLTU produce 1 or 0.
  - COPY_B outputs B unchanged.
- Decode by opcode:
  - OP (0110011): REG/REG. Mode from f3; f7[5] selects SUB or SRA. dest ALU.
  - OP-IMM (0010011): REG/IMM. Same mode mapping, except SUB is never selected; f7[5] selects SRAI only when f3 = 101. dest ALU.
  - LUI (0110111): COPY_B with IMM, dest ALU.
  - AUIPC (0010111): PC/IMM ADD, dest ALU.
  - JAL (1101111): PC/IMM ADD, dest PC, load PC.
  - JALR (1100111): REG/IMM ADD, dest PC, load PC with bit 0 cleared.
  - BRANCH (1100011): REG/REG, dest NONE.
    - BEQ/BNE use XOR; BLT/BGE use SLT; BLTU/BGEU use SLTU.
    - invert = 1 for BEQ, BGE and BGEU.
    - Taken when (alu_out != 0) XOR invert.
  - LOAD (0000011): REG/IMM ADD, dbus_re, dest MEM.
  - STORE (0100011): REG/IMM ADD, dbus_we, dest NONE.
  - Anything else: no-op (dest NONE, PC advances by instr_len).
- PC step is imm for a taken branch, otherwise instr_len.
- PC register update: load has priority over increment; with neither, it holds.
- PC arithmetic wraps modulo 2^32.

## Timing
- States:
  - FETCH: fetch_next_instruction = 1, load_ir = 1. If debug_wait = 1, stay in FETCH. Otherwise move to EXECUTE on the first cycle with stall = 0.
  - EXECUTE: drives the decode signals.
    - While stall = 1: hold all datapath and strobe outputs; load_rd = 0; PC unchanged.
    - On the first cycle with stall = 0: load_rd = 1 if dest ≠ NONE, PC is updated, next state is FETCH.
- Memory strobes are asserted for the whole EXECUTE state, including its first cycle.
- Minimum is 2 cycles per instruction.
- alu_out and the sel outputs are combinational from the current inputs and state.
- next_pc updates on the clock edge that leaves EXECUTE.
- Reset values: state FETCH, next_pc = 0, all strobes 0, dest NONE, sel outputs 0.
- Reset mid-instruction abandons the instruction; no write occurs.

## Configuration
- EXEC_CORE_TRACE_EN defined: on each retiring edge, the block $displays the time, cur_pc, opcode, alu_out and the new next_pc.
- Not defined: no simulation output; the RTL is otherwise identical.

## Structure
- Shared package holds:
  - alu_mode_t;
  - the alu_in_a, alu_in_b and dest_reg_from enums;
  - the opcode constants;
  - int32_t and uint32_t.
- Natural sub-module: `exec_alu`, purely combinational (A, B, mode → out).

## Test plan
- ADDI, rs1 = 5, imm = -3 → alu_out = 2, dest ALU, load_rd pulses once, next_pc += 4.
- BEQ, rs1 = rs2 = 7, imm = 16, cur_pc = 0x100, next_pc = 0x100 → next_pc = 0x110. With rs2 = 8 → next_pc = 0x104.
- BLTU, rs1 = 0xFFFFFFFF, rs2 = 1 → not taken. BLT with the same operands → taken.
- LW with stall held high for 3 cycles in EXECUTE → dbus_re is high for 4 cycles, load_rd pulses only on the final cycle, dest MEM.
- JALR, rs1 = 0x203, imm = 0 → next_pc = 0x202, dest PC.
- SRA, rs1 = 0x80000000, rs2 = 4 → alu_out = 0xF8000000. Reset asserted mid-instruction → next_pc = 0 and state FETCH.
